// File: rtl/instr_issue_sequencer.sv
// Instruction issue sequencer: buffers host words in a small FIFO and holds each on iin
// for an opcode-dependent slot. Optional perf counters are enabled with ISSUE_PERF_COUNT_EN.
module instr_issue_sequencer #(
  parameter int unsigned DEPTH         = 4,
  parameter logic [7:0]  SHORT_OP_MASK = 8'h03,
  parameter int unsigned SHORT_CYCLES  = 2,
  parameter int unsigned LONG_CYCLES   = 4,
  parameter logic [15:0] NOP_WORD      = 16'h0000
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [15:0]              s_instr,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic                     stall,
  input  logic                     flush,
  output logic [15:0]              iin,
  output logic                     issue_pulse,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
`ifdef ISSUE_PERF_COUNT_EN
  ,
  output logic [15:0]              issued_count,
  output logic [15:0]              stall_cycles
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e        state_q, state_d;
  logic [15:0]   mem_q [DEPTH];
  logic [PW-1:0] wrPtr_q, rdPtr_q;
  logic [PW:0]   count_q;
  logic [3:0]    holdCnt_q, holdCnt_d;
  logic [15:0]   iin_q, iin_d;
  logic          pulse_q, pulse_d;
  logic          push, pop, atBoundary, wantPop;
  logic [15:0]   head;
  logic [3:0]    headLen;

  assign s_ready    = resetn & (count_q < DEPTH_C) & ~flush;
  assign push       = s_valid & s_ready;
  assign atBoundary = (state_q == IDLE) || (holdCnt_q == 4'd0);
  assign wantPop    = (count_q != '0) && !flush;
  assign pop        = wantPop && !stall && atBoundary;
  assign head       = mem_q[rdPtr_q];
  assign headLen    = SHORT_OP_MASK[head[15:13]] ? 4'(SHORT_CYCLES) : 4'(LONG_CYCLES);

  // FIFO storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (push) mem_q[wrPtr_q] <= s_instr;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else if (flush) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + PW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      holdCnt_q <= 4'd0;
      iin_q     <= NOP_WORD;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      holdCnt_q <= holdCnt_d;
      iin_q     <= iin_d;
      pulse_q   <= pulse_d;
    end
  end

  // A slot's last cycle behaves like IDLE, which gives back-to-back issue with no NOP gap.
  always_comb begin
    state_d = state_q;
    if (flush)           state_d = IDLE;
    else if (pop)        state_d = HOLD;
    else if (atBoundary) state_d = IDLE;
  end

  always_comb begin
    iin_d     = iin_q;
    holdCnt_d = holdCnt_q;
    pulse_d   = 1'b0;
    if (flush) begin
      iin_d     = NOP_WORD;
      holdCnt_d = 4'd0;
    end else if (pop) begin
      iin_d     = head;
      holdCnt_d = headLen - 4'd1;
      pulse_d   = 1'b1;
    end else if (atBoundary) begin
      iin_d     = NOP_WORD;
      holdCnt_d = 4'd0;
    end else begin
      holdCnt_d = holdCnt_q - 4'd1;
    end
  end

  assign iin         = iin_q;
  assign issue_pulse = pulse_q;
  assign busy        = (state_q == HOLD);
  assign fifo_count  = count_q;

`ifdef ISSUE_PERF_COUNT_EN
  logic [15:0] issuedCnt_q, stallCnt_q;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      issuedCnt_q <= 16'd0;
      stallCnt_q  <= 16'd0;
    end else begin
      if (pop)                            issuedCnt_q <= issuedCnt_q + 16'd1;
      if (wantPop && atBoundary && stall) stallCnt_q  <= stallCnt_q + 16'd1;
    end
  end

  assign issued_count = issuedCnt_q;
  assign stall_cycles = stallCnt_q;
`endif

endmodule

// File: tb/tb_instr_issue_sequencer.sv
// Self-checking bench for instr_issue_sequencer: directed scenarios plus random traffic,
// all compared against a queue-based slot model kept here.
module tb_instr_issue_sequencer;

  localparam int          DEPTH = 4;
  localparam logic [15:0] NOP   = 16'h0000;

  logic        clock = 1'b0;
  logic        resetn;
  logic [15:0] s_instr;
  logic        s_valid;
  logic        s_ready;
  logic        stall;
  logic        flush;
  logic [15:0] iin;
  logic        issue_pulse;
  logic        busy;
  logic [2:0]  fifo_count;
`ifdef ISSUE_PERF_COUNT_EN
  logic [15:0] issued_count;
  logic [15:0] stall_cycles;
`endif

  instr_issue_sequencer #(
    .DEPTH(DEPTH), .SHORT_OP_MASK(8'h03), .SHORT_CYCLES(2), .LONG_CYCLES(4), .NOP_WORD(NOP)
  ) dut (
    .clock(clock), .resetn(resetn), .s_instr(s_instr), .s_valid(s_valid), .s_ready(s_ready),
    .stall(stall), .flush(flush), .iin(iin), .issue_pulse(issue_pulse), .busy(busy),
    .fifo_count(fifo_count)
`ifdef ISSUE_PERF_COUNT_EN
    , .issued_count(issued_count), .stall_cycles(stall_cycles)
`endif
  );

  always #5 clock = ~clock;

  // Reference model: queue of pending words plus the number of cycles left in the current slot.
  logic [15:0] modelQ[$];
  int          slotLeft;
  logic [15:0] expIin;
  logic        expPulse;
  int          issuedM;
  int          stallM;

  int vectors     = 0;
  int miscompares = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int slotLen(input logic [15:0] w);
    logic [7:0] shortMask;
    shortMask = 8'h03;
    return shortMask[w[15:13]] ? 2 : 4;
  endfunction

  task automatic modelReset();
    modelQ.delete();
    slotLeft = 0;
    expIin   = NOP;
    expPulse = 1'b0;
    issuedM  = 0;
    stallM   = 0;
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".iin"}, {16'h0, iin}, {16'h0, expIin});
    checkOutput({tag, ".issue_pulse"}, {31'h0, issue_pulse}, {31'h0, expPulse});
    checkOutput({tag, ".busy"}, {31'h0, busy}, (slotLeft > 0) ? 32'd1 : 32'd0);
    checkOutput({tag, ".fifo_count"}, {29'h0, fifo_count}, modelQ.size());
`ifdef ISSUE_PERF_COUNT_EN
    checkOutput({tag, ".issued_count"}, {16'h0, issued_count}, issuedM & 32'hFFFF);
    checkOutput({tag, ".stall_cycles"}, {16'h0, stall_cycles}, stallM & 32'hFFFF);
`endif
  endtask

  // Drive one cycle of inputs, check the combinational ready, then step the model at the edge.
  task automatic applyStimulus(input logic v, input logic [15:0] instr, input logic st, input logic fl);
    logic        readyExp;
    logic [15:0] w;
    s_valid = v;
    s_instr = instr;
    stall   = st;
    flush   = fl;
    @(negedge clock);
    readyExp = (modelQ.size() < DEPTH) && !fl;
    checkOutput("s_ready", {31'h0, s_ready}, {31'h0, readyExp});
    @(posedge clock);
    if (fl) begin
      modelQ.delete();
      slotLeft = 0;
      expIin   = NOP;
      expPulse = 1'b0;
    end else begin
      if (slotLeft <= 1 && modelQ.size() > 0 && st) stallM++;
      if (slotLeft > 1) begin
        slotLeft--;
        expPulse = 1'b0;
      end else if (modelQ.size() > 0 && !st) begin
        w        = modelQ.pop_front();
        expIin   = w;
        slotLeft = slotLen(w);
        expPulse = 1'b1;
        issuedM++;
      end else begin
        slotLeft = 0;
        expIin   = NOP;
        expPulse = 1'b0;
      end
      if (v && readyExp) modelQ.push_back(instr);
    end
    #1;
    checkAll("cyc");
  endtask

  task automatic doReset();
    resetn  = 1'b0;
    s_valid = 1'b1;
    s_instr = 16'h1234;
    stall   = 1'b0;
    flush   = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    modelReset();
    checkOutput("rst.s_ready", {31'h0, s_ready}, 32'd0);
    checkAll("rst");
    s_valid = 1'b0;
    resetn  = 1'b1;
  endtask

  int pulses, n2001, n8005, n2002, firstIdx, lastIdx;

  initial begin
    // Test 1: reset with s_valid high must not record a push.
    doReset();
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("t1.count_after_reset", {29'h0, fifo_count}, 32'd0);

    // Test 2: back-to-back short/long/short words with no NOP gaps.
    pulses = 0; n2001 = 0; n8005 = 0; n2002 = 0; firstIdx = -1; lastIdx = -1;
    for (int i = 0; i < 14; i++) begin
      case (i)
        0:       applyStimulus(1'b1, 16'h2001, 1'b0, 1'b0);
        1:       applyStimulus(1'b1, 16'h8005, 1'b0, 1'b0);
        2:       applyStimulus(1'b1, 16'h2002, 1'b0, 1'b0);
        default: applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
      endcase
      if (issue_pulse) pulses++;
      if (iin == 16'h2001) n2001++;
      if (iin == 16'h8005) n8005++;
      if (iin == 16'h2002) n2002++;
      if (iin != NOP) begin
        if (firstIdx < 0) firstIdx = i;
        lastIdx = i;
      end
    end
    checkOutput("t2.pulses", pulses, 32'd3);
    checkOutput("t2.cyc_2001", n2001, 32'd2);
    checkOutput("t2.cyc_8005", n8005, 32'd4);
    checkOutput("t2.cyc_2002", n2002, 32'd2);
    checkOutput("t2.span", lastIdx - firstIdx + 1, 32'd8);

    // Test 3: fill while stalled, then release; the fifth word enters after the first pop.
    applyStimulus(1'b1, 16'h8101, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h2102, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'hA103, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h0104, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'hE105, 1'b1, 1'b0);
    checkOutput("t3.full_count", {29'h0, fifo_count}, 32'd4);
    checkOutput("t3.full_ready", {31'h0, s_ready}, 32'd0);
    applyStimulus(1'b1, 16'hE105, 1'b0, 1'b0);
    checkOutput("t3.count_after_pop", {29'h0, fifo_count}, 32'd3);
    applyStimulus(1'b1, 16'hE105, 1'b0, 1'b0);
    checkOutput("t3.fifth_accepted", {29'h0, fifo_count}, 32'd4);
    repeat (20) applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);

    // Test 4: stall during a long slot does not shorten or extend it.
    applyStimulus(1'b1, 16'h8005, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h2003, 1'b0, 1'b0);
    checkOutput("t4.issued", {16'h0, iin}, 32'h8005);
    repeat (3) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("t4.last_cycle", {16'h0, iin}, 32'h8005);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("t4.nop_after", {16'h0, iin}, 32'h0);
    checkOutput("t4.no_pop", {29'h0, fifo_count}, 32'd1);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("t4.next_word", {16'h0, iin}, 32'h2003);
    repeat (4) applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);

    // Test 5: flush mid-slot drops queued and concurrent words.
    applyStimulus(1'b1, 16'h8011, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h8012, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h8013, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h8014, 1'b0, 1'b1);
    checkOutput("t5.iin", {16'h0, iin}, 32'h0);
    checkOutput("t5.busy", {31'h0, busy}, 32'd0);
    checkOutput("t5.count", {29'h0, fifo_count}, 32'd0);
    repeat (3) applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a slot.
    applyStimulus(1'b1, 16'h8021, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h8022, 1'b0, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    modelReset();
    checkOutput("arst.s_ready", {31'h0, s_ready}, 32'd0);
    checkAll("arst");
    @(posedge clock);
    #1;
    s_valid = 1'b0;
    resetn  = 1'b1;

`ifdef ISSUE_PERF_COUNT_EN
    // Test 6: two stalled boundary cycles and three issues; flush must not clear counters.
    applyStimulus(1'b1, 16'h2001, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h2002, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h2003, 1'b0, 1'b0);
    repeat (10) applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("t6.issued", {16'h0, issued_count}, 32'd3);
    checkOutput("t6.stalls", {16'h0, stall_cycles}, 32'd2);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
    checkOutput("t6.issued_flush", {16'h0, issued_count}, 32'd3);
    checkOutput("t6.stalls_flush", {16'h0, stall_cycles}, 32'd2);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 99) < 60, 16'($urandom),
                    $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 3);
    end

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
